// File: rtl/fp2int_conv.sv
// IEEE-754 binary32 to 32-bit integer converter (FCVT.W.S / FCVT.WU.S).
// Multi-cycle pipeline with a valid/ready request and a valid/ready response.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// UNPACK | classify captured operand (zero/denormal, normal, inf, NaN)
// ALIGN  | shift significand to integer position, form guard and sticky
// ROUND  | apply rounding, saturation and flags
// DONE   | hold result until resp_ready
module fp2int_conv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] op_a,
    input  logic        is_unsigned,
    input  logic [2:0]  rm,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_result;
    logic [4:0]  r_fflags;

    logic        r_sign;
    logic [7:0]  r_exp;
    logic [22:0] r_frac;
    logic        r_uns;
    logic [2:0]  r_rm;

    logic        r_cls_nan;
    logic        r_cls_inf;
    logic        r_cls_small;

    logic [31:0] r_mag;
    logic        r_guard;
    logic        r_sticky;
    logic        r_big;

    logic [23:0] w_sig;
    logic [7:0]  w_rsh;
    logic [7:0]  w_lsh;
    logic [47:0] w_rshifted;
    logic [31:0] w_lshifted;

    logic        w_inc;
    logic        w_inexact;
    logic [32:0] w_mag33;
    logic [31:0] w_neg;
    logic [31:0] w_res;
    logic        w_nv;
    logic        w_nx;

    assign w_sig      = {1'b1, r_frac};
    assign w_rsh      = 8'd150 - r_exp;
    assign w_lsh      = r_exp - 8'd150;
    assign w_rshifted = {w_sig, 24'b0} >> w_rsh;
    assign w_lshifted = {8'b0, w_sig} << w_lsh[3:0];

    assign w_inexact  = r_guard | r_sticky;
    assign w_mag33    = {1'b0, r_mag} + {32'b0, w_inc};
    assign w_neg      = ~w_mag33[31:0] + 32'd1;

    always_comb begin
        w_inc = 1'b0;
        case (r_rm)
            RM_RNE:  w_inc = r_guard & (r_sticky | r_mag[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r_sign & w_inexact;
            RM_RUP:  w_inc = ~r_sign & w_inexact;
            RM_RMM:  w_inc = r_guard;
            default: w_inc = 1'b0;
        endcase
    end

    always_comb begin
        w_res = 32'd0;
        w_nv  = 1'b0;
        w_nx  = 1'b0;
        if (r_cls_nan) begin
            w_res = r_uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            w_nv  = 1'b1;
        end else if (r_cls_inf || r_big) begin
            // infinities and |x| >= 2^32 saturate toward the operand's sign
            w_nv = 1'b1;
            if (r_uns)
                w_res = r_sign ? 32'h0000_0000 : 32'hFFFF_FFFF;
            else
                w_res = r_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (r_uns) begin
            if (!r_sign) begin
                if (w_mag33[32]) begin
                    w_res = 32'hFFFF_FFFF;
                    w_nv  = 1'b1;
                end else begin
                    w_res = w_mag33[31:0];
                    w_nx  = w_inexact;
                end
            end else if (w_mag33 != 33'd0) begin
                w_res = 32'h0000_0000;
                w_nv  = 1'b1;
            end else begin
                w_res = 32'h0000_0000;
                w_nx  = w_inexact;
            end
        end else begin
            if (!r_sign) begin
                if (w_mag33 > 33'h0_7FFF_FFFF) begin
                    w_res = 32'h7FFF_FFFF;
                    w_nv  = 1'b1;
                end else begin
                    w_res = w_mag33[31:0];
                    w_nx  = w_inexact;
                end
            end else begin
                if (w_mag33 > 33'h0_8000_0000) begin
                    w_res = 32'h8000_0000;
                    w_nv  = 1'b1;
                end else begin
                    w_res = w_neg;
                    w_nx  = w_inexact;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_result     <= 32'd0;
            r_fflags     <= 5'd0;
            r_sign       <= 1'b0;
            r_exp        <= 8'd0;
            r_frac       <= 23'd0;
            r_uns        <= 1'b0;
            r_rm         <= 3'd0;
            r_cls_nan    <= 1'b0;
            r_cls_inf    <= 1'b0;
            r_cls_small  <= 1'b0;
            r_mag        <= 32'd0;
            r_guard      <= 1'b0;
            r_sticky     <= 1'b0;
            r_big        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_sign      <= op_a[31];
                        r_exp       <= op_a[30:23];
                        r_frac      <= op_a[22:0];
                        r_uns       <= is_unsigned;
                        r_rm        <= rm;
                        r_req_ready <= 1'b0;
                        r_state     <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_cls_nan   <= (r_exp == 8'hFF) && (r_frac != 23'd0);
                    r_cls_inf   <= (r_exp == 8'hFF) && (r_frac == 23'd0);
                    r_cls_small <= (r_exp < 8'd126);
                    r_state     <= S_ALIGN;
                end
                S_ALIGN: begin
                    r_big    <= 1'b0;
                    r_mag    <= 32'd0;
                    r_guard  <= 1'b0;
                    r_sticky <= 1'b0;
                    if (r_cls_nan || r_cls_inf) begin
                        r_big <= 1'b0;
                    end else if (r_cls_small) begin
                        // denormals land here too: exp is 0 so only frac matters
                        r_sticky <= (r_exp != 8'd0) || (r_frac != 23'd0);
                    end else if (r_exp >= 8'd159) begin
                        r_big <= 1'b1;
                    end else if (r_exp >= 8'd150) begin
                        r_mag <= w_lshifted;
                    end else begin
                        r_mag    <= {8'b0, w_rshifted[47:24]};
                        r_guard  <= w_rshifted[23];
                        r_sticky <= |w_rshifted[22:0];
                    end
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_result     <= w_res;
                    r_fflags     <= {w_nv, 3'b000, w_nx};
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign result     = r_result;
    assign fflags     = r_fflags;

endmodule

// File: tb/tb_fp2int_conv.sv
// Directed-vector bench for fp2int_conv: values, flags, latency, hold and reset.
module tb_fp2int_conv;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] op_a;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic [4:0]  fflags;

    int n_chk;
    int n_err;

    fp2int_conv u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .op_a        (op_a),
        .is_unsigned (is_unsigned),
        .rm          (rm),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .result      (result),
        .fflags      (fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // issue one request and wait for resp_valid; leaves the response un-acknowledged
    task automatic issue_wait(input string tag, input logic [31:0] op, input logic uns,
                              input logic [2:0] mode, input logic [31:0] exp_res,
                              input logic [4:0] exp_flg);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        op_a        = op;
        is_unsigned = uns;
        rm          = mode;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        op_a        = $urandom;
        is_unsigned = ~uns;
        rm          = 3'(mode + 3'd1);
        check_val({tag, ".busy"}, {31'b0, req_ready}, 32'd0);
        n = 0;
        while (!resp_valid && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, ".latency"}, n, 32'd3);
        check_val({tag, ".result"}, result, exp_res);
        check_val({tag, ".fflags"}, {27'b0, fflags}, {27'b0, exp_flg});
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_val({tag, ".vld_low"}, {31'b0, resp_valid}, 32'd0);
        check_val({tag, ".idle"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic convert(input string tag, input logic [31:0] op, input logic uns,
                           input logic [2:0] mode, input logic [31:0] exp_res,
                           input logic [4:0] exp_flg);
        issue_wait(tag, op, uns, mode, exp_res, exp_flg);
        handshake(tag);
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        op_a        = 32'd0;
        is_unsigned = 1'b0;
        rm          = 3'd0;
        resp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        check_val("rst.result", result, 32'd0);
        check_val("rst.fflags", {27'b0, fflags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst.req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);

        convert("p1_5_rne",   32'h3FC0_0000, 1'b0, 3'b000, 32'h0000_0002, 5'h01);
        convert("p1_5_rtz",   32'h3FC0_0000, 1'b0, 3'b001, 32'h0000_0001, 5'h01);
        convert("m2_5_rne",   32'hC020_0000, 1'b0, 3'b000, 32'hFFFF_FFFE, 5'h01);
        convert("m2_5_rmm",   32'hC020_0000, 1'b0, 3'b100, 32'hFFFF_FFFD, 5'h01);
        convert("m2_5_rup",   32'hC020_0000, 1'b0, 3'b011, 32'hFFFF_FFFE, 5'h01);
        convert("p2_31_s",    32'h4F00_0000, 1'b0, 3'b000, 32'h7FFF_FFFF, 5'h10);
        convert("m2_31_s",    32'hCF00_0000, 1'b0, 3'b000, 32'h8000_0000, 5'h00);
        convert("nan_s",      32'h7FC0_0000, 1'b0, 3'b000, 32'h7FFF_FFFF, 5'h10);
        convert("m1_u",       32'hBF80_0000, 1'b1, 3'b000, 32'h0000_0000, 5'h10);
        convert("m0_3_u_rtz", 32'hBE99_999A, 1'b1, 3'b001, 32'h0000_0000, 5'h01);
        convert("p2_32_u",    32'h4F80_0000, 1'b1, 3'b000, 32'hFFFF_FFFF, 5'h10);
        convert("zero",       32'h0000_0000, 1'b0, 3'b000, 32'h0000_0000, 5'h00);
        convert("negzero_u",  32'h8000_0000, 1'b1, 3'b010, 32'h0000_0000, 5'h00);
        convert("minf_s",     32'hFF80_0000, 1'b0, 3'b000, 32'h8000_0000, 5'h10);
        convert("pinf_u",     32'h7F80_0000, 1'b1, 3'b000, 32'hFFFF_FFFF, 5'h10);
        convert("nnan_u",     32'hFFC0_0001, 1'b1, 3'b000, 32'hFFFF_FFFF, 5'h10);
        convert("p1_5_rdn",   32'h3FC0_0000, 1'b0, 3'b010, 32'h0000_0001, 5'h01);
        convert("m1_5_rdn",   32'hBFC0_0000, 1'b0, 3'b010, 32'hFFFF_FFFE, 5'h01);
        convert("p2_5_rne",   32'h4020_0000, 1'b0, 3'b000, 32'h0000_0002, 5'h01);
        convert("p1_exact",   32'h3F80_0000, 1'b0, 3'b000, 32'h0000_0001, 5'h00);
        convert("rm101",      32'h3FC0_0000, 1'b0, 3'b101, 32'h0000_0001, 5'h01);
        convert("rm111_neg",  32'hBFC0_0000, 1'b0, 3'b111, 32'hFFFF_FFFF, 5'h01);
        convert("half_rne",   32'h3F00_0000, 1'b0, 3'b000, 32'h0000_0000, 5'h01);
        convert("half_rup",   32'h3F00_0000, 1'b0, 3'b011, 32'h0000_0001, 5'h01);
        convert("mhalf_u_up", 32'hBF00_0000, 1'b1, 3'b011, 32'h0000_0000, 5'h01);
        convert("mhalf_u_dn", 32'hBF00_0000, 1'b1, 3'b010, 32'h0000_0000, 5'h10);
        convert("denorm_rup", 32'h0000_0001, 1'b0, 3'b011, 32'h0000_0001, 5'h01);
        convert("max_u",      32'h4F7F_FFFF, 1'b1, 3'b000, 32'hFFFF_FF00, 5'h00);
        convert("max_s",      32'h4EFF_FFFF, 1'b0, 3'b000, 32'h7FFF_FF80, 5'h00);
        convert("below_m2_31",32'hCF00_0001, 1'b0, 3'b000, 32'h8000_0000, 5'h10);

        // response held: outputs stable, new request ignored
        issue_wait("hold", 32'h4020_0000, 1'b0, 3'b011, 32'h0000_0003, 5'h01);
        req_valid   = 1'b1;
        op_a        = 32'h3F80_0000;
        is_unsigned = 1'b0;
        rm          = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("hold.valid", {31'b0, resp_valid}, 32'd1);
            check_val("hold.result", result, 32'h0000_0003);
            check_val("hold.fflags", {27'b0, fflags}, 32'h0000_0001);
            check_val("hold.req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        handshake("hold");

        // reset asserted mid-conversion
        convert("pre_rst", 32'h4F80_0000, 1'b1, 3'b000, 32'hFFFF_FFFF, 5'h10);
        @(negedge clk);
        req_valid   = 1'b1;
        op_a        = 32'h3FC0_0000;
        is_unsigned = 1'b0;
        rm          = 3'b000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst.resp_valid", {31'b0, resp_valid}, 32'd0);
        check_val("arst.result", result, 32'd0);
        check_val("arst.fflags", {27'b0, fflags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        convert("post_rst", 32'hC020_0000, 1'b0, 3'b100, 32'hFFFF_FFFD, 5'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
